// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the microcode sequencer: microword field positions,
// branch-condition codes, FSM state encoding and the decode-address helper.
package micro_sequencer_pkg;

  localparam int unsigned FLD_A_HI     = 40;
  localparam int unsigned FLD_A_LO     = 35;
  localparam int unsigned FLD_AMUX     = 34;
  localparam int unsigned FLD_B_HI     = 33;
  localparam int unsigned FLD_B_LO     = 28;
  localparam int unsigned FLD_BMUX     = 27;
  localparam int unsigned FLD_C_HI     = 26;
  localparam int unsigned FLD_C_LO     = 21;
  localparam int unsigned FLD_CMUX     = 20;
  localparam int unsigned FLD_RD       = 19;
  localparam int unsigned FLD_WR       = 18;
  localparam int unsigned FLD_ALU_HI   = 17;
  localparam int unsigned FLD_ALU_LO   = 14;
  localparam int unsigned FLD_COND_HI  = 13;
  localparam int unsigned FLD_COND_LO  = 11;
  localparam int unsigned FLD_JADDR_HI = 10;
  localparam int unsigned FLD_JADDR_LO = 0;

  localparam logic [2:0] COND_NEXT   = 3'b000;
  localparam logic [2:0] COND_N      = 3'b001;
  localparam logic [2:0] COND_Z      = 3'b010;
  localparam logic [2:0] COND_V      = 3'b011;
  localparam logic [2:0] COND_C      = 3'b100;
  localparam logic [2:0] COND_IR13   = 3'b101;
  localparam logic [2:0] COND_JUMP   = 3'b110;
  localparam logic [2:0] COND_DECODE = 3'b111;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_WAIT_MEM = 1'b1
  } seq_state_e;

  // Each opcode owns a block of four microwords in the upper half of the store.
  function automatic logic [10:0] decode_addr(input logic [1:0] op, input logic [5:0] op3);
    return {1'b1, op, op3, 2'b00};
  endfunction

endpackage

// File: rtl/micro_sequencer_next_addr.sv
// Combinational next-microPC selection: increment, conditional/unconditional
// jump, or opcode decode dispatch.
module micro_next_addr
  import micro_sequencer_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic [2:0]        cond_i,
  input  logic [ADDR_W-1:0] jaddr_i,
  input  logic [31:0]       ir_i,
  input  logic [3:0]        flags_i,
  input  logic [ADDR_W-1:0] upc_i,
  output logic [ADDR_W-1:0] next_addr_o
);

  logic              take;
  logic [ADDR_W-1:0] incr;
  logic              unused_ir;

  assign incr      = upc_i + ADDR_W'(1);
  assign unused_ir = ^{ir_i[29:25], ir_i[18:14], ir_i[12:0]};

  always_comb begin
    take        = 1'b0;
    next_addr_o = incr;
    case (cond_i)
      COND_NEXT:   take = 1'b0;
      COND_N:      take = flags_i[3];
      COND_Z:      take = flags_i[2];
      COND_V:      take = flags_i[1];
      COND_C:      take = flags_i[0];
      COND_IR13:   take = ir_i[13];
      COND_JUMP:   take = 1'b1;
      COND_DECODE: next_addr_o = ADDR_W'(decode_addr(ir_i[31:30], ir_i[24:19]));
      default:     take = 1'b0;
    endcase
    if (take) begin
      next_addr_o = jaddr_i;
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microcode sequencer: microPC register plus a RUN/WAIT_MEM FSM that freezes
// the microPC while a memory microword waits for its completion strobe.
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int WORD_W = 41
) (
  input  logic              MicroSeq_CLOCK_50,
  input  logic              MicroSeq_RESET_InHigh,
  input  logic [WORD_W-1:0] MicroSeq_Word_In,
  input  logic [31:0]       MicroSeq_IR_In,
  input  logic [3:0]        MicroSeq_Flags_In,
  input  logic              MicroSeq_MemDone_In,
  output logic [ADDR_W-1:0] MicroSeq_Addr_Out,
  output logic              MicroSeq_Stall_Out
);

  seq_state_e        state_q;
  logic [ADDR_W-1:0] upc_q;
  logic [ADDR_W-1:0] upc_d;
  logic              mem_op;
  logic              unused_fields;

  assign mem_op = MicroSeq_Word_In[FLD_RD] | MicroSeq_Word_In[FLD_WR];

  assign unused_fields = ^{MicroSeq_Word_In[FLD_A_HI:FLD_A_LO], MicroSeq_Word_In[FLD_AMUX],
                           MicroSeq_Word_In[FLD_B_HI:FLD_B_LO], MicroSeq_Word_In[FLD_BMUX],
                           MicroSeq_Word_In[FLD_C_HI:FLD_C_LO], MicroSeq_Word_In[FLD_CMUX],
                           MicroSeq_Word_In[FLD_ALU_HI:FLD_ALU_LO]};

  micro_next_addr #(
    .ADDR_W (ADDR_W)
  ) u_next_addr (
    .cond_i      (MicroSeq_Word_In[FLD_COND_HI:FLD_COND_LO]),
    .jaddr_i     (MicroSeq_Word_In[FLD_JADDR_HI:FLD_JADDR_LO]),
    .ir_i        (MicroSeq_IR_In),
    .flags_i     (MicroSeq_Flags_In),
    .upc_i       (upc_q),
    .next_addr_o (upc_d)
  );

  always_ff @(posedge MicroSeq_CLOCK_50 or posedge MicroSeq_RESET_InHigh) begin
    if (MicroSeq_RESET_InHigh) begin
      state_q <= ST_RUN;
      upc_q   <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!mem_op || MicroSeq_MemDone_In) begin
            upc_q <= upc_d;
          end else begin
            state_q <= ST_WAIT_MEM;
          end
        end
        ST_WAIT_MEM: begin
          if (MicroSeq_MemDone_In) begin
            upc_q   <= upc_d;
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign MicroSeq_Addr_Out = upc_q;

  // Stall follows the strobe in the same cycle; reset masks the RUN-state term.
  assign MicroSeq_Stall_Out = !MicroSeq_RESET_InHigh &&
                              ((state_q == ST_WAIT_MEM) || (mem_op && !MicroSeq_MemDone_In));

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: expected microPC values are queued
// when a microword is driven and compared after the consuming clock edge.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [40:0] word;
  logic [31:0] ir;
  logic [3:0]  flags;
  logic        md;
  logic [10:0] addr;
  logic        stall;

  int          total = 0;
  int          bad = 0;
  logic [10:0] exp_q[$];
  logic [10:0] exp_a;

  always #5 clk = ~clk;

  micro_sequencer #(.ADDR_W(11), .WORD_W(41)) dut (
    .MicroSeq_CLOCK_50     (clk),
    .MicroSeq_RESET_InHigh (rst),
    .MicroSeq_Word_In      (word),
    .MicroSeq_IR_In        (ir),
    .MicroSeq_Flags_In     (flags),
    .MicroSeq_MemDone_In   (md),
    .MicroSeq_Addr_Out     (addr),
    .MicroSeq_Stall_Out    (stall)
  );

  function automatic logic [40:0] mk_word(input logic [2:0] cond, input logic [10:0] jaddr,
                                          input logic rd, input logic wr);
    logic [40:0] w;
    w        = 41'({$urandom(), $urandom()});
    w[13:11] = cond;
    w[10:0]  = jaddr;
    w[19]    = rd;
    w[18]    = wr;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [40:0] w, input logic [31:0] i, input logic [3:0] f, input logic m);
    word  = w;
    ir    = i;
    flags = f;
    md    = m;
  endtask

  task automatic jump_to(input logic [10:0] target, input string nm);
    drive(mk_word(3'b110, target, 1'b0, 1'b0), $urandom(), 4'($urandom()), 1'b0);
    exp_q.push_back(target);
    step();
    exp_a = exp_q.pop_front();
    total++;
    if (addr !== exp_a) begin
      bad++;
      $display("FAIL %s jump: addr got %0d want %0d", nm, addr, exp_a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(mk_word(3'b000, 11'd0, 1'b1, 1'b0), 32'h0, 4'h0, 1'b0);
    #2 rst = 1'b1;
    #2;
    total++;
    if (addr !== 11'd0) begin
      bad++;
      $display("FAIL reset addr: got %0d want 0", addr);
    end
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL reset stall: got %b want 0", stall);
    end
    step();
    step();
    total++;
    if (addr !== 11'd0) begin
      bad++;
      $display("FAIL reset held addr: got %0d want 0", addr);
    end
  endtask

  task automatic test_run();
    rst = 1'b0;
    total++;
    if (addr !== 11'd0) begin
      bad++;
      $display("FAIL run start addr: got %0d want 0", addr);
    end
    for (int k = 1; k <= 3; k++) begin
      // MemDone pulsed on a non-memory word must be ignored
      drive(mk_word(3'b000, 11'($urandom()), 1'b0, 1'b0), $urandom(), 4'($urandom()), k == 2);
      exp_q.push_back(11'(k));
      step();
      exp_a = exp_q.pop_front();
      total++;
      if (addr !== exp_a) begin
        bad++;
        $display("FAIL run step %0d: addr got %0d want %0d", k, addr, exp_a);
      end
      total++;
      if (stall !== 1'b0) begin
        bad++;
        $display("FAIL run stall %0d: got %b want 0", k, stall);
      end
    end
  endtask

  task automatic test_decode();
    logic [31:0] dir[2] = '{32'hC020_0000, 32'h8080_0000};
    logic [10:0] dex[2] = '{11'b11100010000, 11'b11001000000};
    logic [31:0] irv;
    for (int k = 0; k < 2; k++) begin
      jump_to(11'd300, "decode");
      irv = dir[k] | ($urandom() & 32'h3E07_FFFF);
      drive(mk_word(3'b111, 11'($urandom()), 1'b0, 1'b0), irv, 4'($urandom()), 1'b0);
      exp_q.push_back(dex[k]);
      step();
      exp_a = exp_q.pop_front();
      total++;
      if (addr !== exp_a) begin
        bad++;
        $display("FAIL decode %0d ir=%h: addr got %b want %b", k, irv, addr, exp_a);
      end
    end
  endtask

  task automatic test_branch();
    logic [3:0]  fl;
    logic [31:0] irv;
    for (int e = 0; e < 5; e++) begin
      for (int t = 0; t < 2; t++) begin
        jump_to(11'd100, "branch");
        if (e < 4) begin
          fl  = 4'(1 << (3 - e));
          fl  = (t == 1) ? fl : ~fl;
          irv = (t == 1) ? 32'h0000_0000 : 32'h0000_2000;
        end else begin
          fl  = (t == 1) ? 4'h0 : 4'hF;
          irv = (t == 1) ? 32'h0000_2000 : 32'hFFFF_DFFF;
        end
        drive(mk_word(3'(e + 1), 11'd12, 1'b0, 1'b0), irv, fl, 1'b0);
        exp_q.push_back((t == 1) ? 11'd12 : 11'd101);
        step();
        exp_a = exp_q.pop_front();
        total++;
        if (addr !== exp_a) begin
          bad++;
          $display("FAIL branch cond=%0d taken=%0d: addr got %0d want %0d", e + 1, t, addr, exp_a);
        end
      end
    end
  endtask

  task automatic test_stall();
    rst = 1'b1;
    #2 rst = 1'b0;
    drive(mk_word(3'b000, 11'd0, 1'b1, 1'b0), 32'h0, 4'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (stall !== 1'b1) begin
        bad++;
        $display("FAIL stall wait %0d: stall got %b want 1", k, stall);
      end
      exp_q.push_back(11'd0);
      step();
      exp_a = exp_q.pop_front();
      total++;
      if (addr !== exp_a) begin
        bad++;
        $display("FAIL stall hold %0d: addr got %0d want %0d", k, addr, exp_a);
      end
    end
    md = 1'b1;
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL stall done-cycle: stall got %b want 1", stall);
    end
    exp_q.push_back(11'd1);
    step();
    exp_a = exp_q.pop_front();
    total++;
    if (addr !== exp_a) begin
      bad++;
      $display("FAIL stall release: addr got %0d want %0d", addr, exp_a);
    end
    drive(mk_word(3'b000, 11'd0, 1'b0, 1'b0), 32'h0, 4'h0, 1'b0);
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL stall after release: stall got %b want 0", stall);
    end
    exp_q.push_back(11'd2);
    step();
    exp_a = exp_q.pop_front();
    total++;
    if (addr !== exp_a) begin
      bad++;
      $display("FAIL stall next: addr got %0d want %0d", addr, exp_a);
    end
    // the word on the MemDone edge, not the one that started the wait, picks next_addr
    drive(mk_word(3'b000, 11'd0, 1'b0, 1'b1), 32'h0, 4'h0, 1'b0);
    exp_q.push_back(11'd2);
    step();
    exp_a = exp_q.pop_front();
    total++;
    if (addr !== exp_a) begin
      bad++;
      $display("FAIL write wait hold: addr got %0d want %0d", addr, exp_a);
    end
    drive(mk_word(3'b110, 11'd500, 1'b0, 1'b1), 32'h0, 4'h0, 1'b1);
    exp_q.push_back(11'd500);
    step();
    exp_a = exp_q.pop_front();
    total++;
    if (addr !== exp_a) begin
      bad++;
      $display("FAIL wait word swap: addr got %0d want %0d", addr, exp_a);
    end
    drive(mk_word(3'b000, 11'd0, 1'b1, 1'b1), 32'h0, 4'h0, 1'b1);
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL same-cycle done stall: got %b want 0", stall);
    end
    exp_q.push_back(11'd501);
    step();
    exp_a = exp_q.pop_front();
    total++;
    if (addr !== exp_a) begin
      bad++;
      $display("FAIL same-cycle done addr: got %0d want %0d", addr, exp_a);
    end
    drive(mk_word(3'b000, 11'd0, 1'b0, 1'b0), 32'h0, 4'h0, 1'b0);
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL same-cycle stays RUN: stall got %b want 0", stall);
    end
    exp_q.push_back(11'd502);
    step();
    exp_a = exp_q.pop_front();
    total++;
    if (addr !== exp_a) begin
      bad++;
      $display("FAIL same-cycle next: addr got %0d want %0d", addr, exp_a);
    end
  endtask

  task automatic test_wrap();
    jump_to(11'd2047, "wrap");
    drive(mk_word(3'b000, 11'd5, 1'b0, 1'b0), 32'h0, 4'hF, 1'b0);
    exp_q.push_back(11'd0);
    step();
    exp_a = exp_q.pop_front();
    total++;
    if (addr !== exp_a) begin
      bad++;
      $display("FAIL wrap: addr got %0d want %0d", addr, exp_a);
    end
  endtask

  task automatic test_reset_mid_wait();
    jump_to(11'd5, "midwait");
    drive(mk_word(3'b000, 11'd0, 1'b1, 1'b0), 32'h0, 4'h0, 1'b0);
    exp_q.push_back(11'd5);
    step();
    exp_a = exp_q.pop_front();
    total++;
    if (addr !== exp_a) begin
      bad++;
      $display("FAIL midwait enter: addr got %0d want %0d", addr, exp_a);
    end
    #2;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL midwait stall: got %b want 1", stall);
    end
    rst = 1'b1;
    #1;
    total++;
    if (addr !== 11'd0) begin
      bad++;
      $display("FAIL midwait async addr: got %0d want 0", addr);
    end
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL midwait async stall: got %b want 0", stall);
    end
    #3 rst = 1'b0;
    drive(mk_word(3'b000, 11'd0, 1'b0, 1'b0), 32'h0, 4'h0, 1'b0);
    exp_q.push_back(11'd1);
    step();
    exp_a = exp_q.pop_front();
    total++;
    if (addr !== exp_a) begin
      bad++;
      $display("FAIL midwait first edge: addr got %0d want %0d", addr, exp_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] m_upc;
    logic        m_wait;
    logic [2:0]  c;
    logic [10:0] ja;
    logic [10:0] nxt;
    logic        r, w, m, tk, es;
    logic [3:0]  f;
    logic [31:0] iv;
    m_upc  = 11'd1;
    m_wait = 1'b0;
    for (int k = 0; k < 60; k++) begin
      c  = 3'($urandom_range(0, 7));
      ja = 11'($urandom());
      r  = ($urandom_range(0, 3) == 0);
      w  = ($urandom_range(0, 3) == 0);
      m  = 1'($urandom());
      f  = 4'($urandom());
      iv = $urandom();
      case (c)
        3'd1: tk = f[3];
        3'd2: tk = f[2];
        3'd3: tk = f[1];
        3'd4: tk = f[0];
        3'd5: tk = iv[13];
        3'd6: tk = 1'b1;
        default: tk = 1'b0;
      endcase
      nxt = tk ? ja : m_upc + 11'd1;
      if (c == 3'd7) nxt = {1'b1, iv[31:30], iv[24:19], 2'b00};
      es = m_wait || ((r || w) && !m);
      if (m_wait ? m : (!(r || w) || m)) m_upc = nxt;
      m_wait = m_wait ? !m : ((r || w) && !m);
      drive(mk_word(c, ja, r, w), iv, f, m);
      #1;
      total++;
      if (stall !== es) begin
        bad++;
        $display("FAIL b2b stall %0d: got %b want %b", k, stall, es);
      end
      exp_q.push_back(m_upc);
      step();
      exp_a = exp_q.pop_front();
      total++;
      if (addr !== exp_a) begin
        bad++;
        $display("FAIL b2b addr %0d: got %0d want %0d", k, addr, exp_a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_decode();
    test_branch();
    test_stall();
    test_wrap();
    test_reset_mid_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
